// File: rtl/vga_capture.sv
// vga_capture: VGA receive monitor. Registers hsync, vsync and RGB on clk_i,
// rebuilds line and frame position, locks onto the configured timing and
// strobes out every active pixel with its coordinates and colour.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   vga_hs_i, vga_vs_i    sync inputs (asserted level set by SYNC_POL)
//   vga_rgb_i             pixel colour
//   locked_o              high while the timing is locked
//   pix_valid_o           one strobe per active pixel, 2 clocks after the sample
//   pix_x_o, pix_y_o      active-area coordinates of the strobed pixel
//   pix_rgb_o             captured colour (held between strobes)
//   sof_o                 high with the strobe of pixel (0,0)
//   err_o, err_cnt_o      violation pulse and saturating violation count
//   frame_crc_o           CRC-16-CCITT of the last fully locked frame
//   crc_valid_o           one-cycle pulse when frame_crc_o is updated
//
// Build option: define VGA_CAPTURE_CRC_EN to build the per-frame CRC;
// without it frame_crc_o and crc_valid_o are tied to 0.
`ifndef VGA_RGB_W
`define VGA_RGB_W 12
`endif
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif

module vga_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int PIX_DIV  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vga_hs_i,
    input  logic                  vga_vs_i,
    input  logic [`VGA_RGB_W-1:0] vga_rgb_i,
    output logic                  locked_o,
    output logic                  pix_valid_o,
    output logic [`X_POS_W-1:0]   pix_x_o,
    output logic [`Y_POS_W-1:0]   pix_y_o,
    output logic [`VGA_RGB_W-1:0] pix_rgb_o,
    output logic                  sof_o,
    output logic                  err_o,
    output logic [7:0]            err_cnt_o,
    output logic [15:0]           frame_crc_o,
    output logic                  crc_valid_o
);
    localparam int RGB_W   = `VGA_RGB_W;
    localparam int H_LINE  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // pixels per line
    localparam int H_TOTAL = H_LINE * PIX_DIV;                  // clocks per line
    localparam int H_MAX   = 2 * H_TOTAL;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_MAX   = 2 * V_TOTAL;
    localparam int HW      = $clog2(H_MAX + 1);
    localparam int XCW     = $clog2(2 * H_LINE + 1);
    localparam int VW      = $clog2(V_MAX + 1);
    localparam int PW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [HW-1:0]  H_SAT  = HW'(H_MAX);
    localparam logic [HW-1:0]  H_TMO  = HW'(H_MAX - 1);
    localparam logic [HW-1:0]  H_END  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_SAT  = VW'(V_MAX);
    localparam logic [VW-1:0]  V_END  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  Y_LO   = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0]  Y_HI   = VW'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [XCW-1:0] X_LO   = XCW'(H_SYNC + H_BP);
    localparam logic [XCW-1:0] X_HI   = XCW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [PW-1:0]  PH_END = PW'(PIX_DIV - 1);
    localparam logic           POL    = (SYNC_POL != 0);

    typedef enum logic [1:0] {UNLOCKED, MEASURE, LOCKED} state_t;
    state_t state, state_nxt;

    logic             hs_r, vs_r, hs_q, vs_q;
    logic [RGB_W-1:0] rgb_r;
    logic [HW-1:0]    h_cnt, h_nxt;
    logic [PW-1:0]    ph_cnt, ph_nxt;     // clock within the current pixel
    logic [XCW-1:0]   px_cnt, px_nxt;     // h_cnt / PIX_DIV, kept incrementally
    logic [VW-1:0]    v_cnt, v_nxt;
    logic             vs_pend, vs_pend_nxt, meas_bad, meas_bad_nxt;
    logic             hs_edge, vs_edge, v_clr, h_ok, v_ok, timeout, viol, pix_hit;

    assign hs_edge = (hs_r == POL) && (hs_q != POL);
    assign vs_edge = (vs_r == POL) && (vs_q != POL);
    // A line start with a pending (or simultaneous) vsync starts a new frame.
    assign v_clr   = hs_edge && (vs_pend || vs_edge);
    assign h_ok    = (h_cnt == H_END);
    assign v_ok    = (v_cnt == V_END);
    // Fires once, in the cycle the counter steps onto its saturation value.
    assign timeout = !hs_edge && (h_cnt == H_TMO);
    assign locked_o = (state == LOCKED);

    always_comb begin
        h_nxt       = h_cnt;
        ph_nxt      = ph_cnt;
        px_nxt      = px_cnt;
        v_nxt       = v_cnt;
        vs_pend_nxt = vs_pend;
        if (hs_edge) begin
            h_nxt  = '0;
            ph_nxt = '0;
            px_nxt = '0;
        end else if (h_cnt != H_SAT) begin
            h_nxt = h_cnt + 1'b1;
            if (ph_cnt == PH_END) begin
                ph_nxt = '0;
                px_nxt = px_cnt + 1'b1;
            end else begin
                ph_nxt = ph_cnt + 1'b1;
            end
        end
        if (v_clr) begin
            v_nxt       = '0;
            vs_pend_nxt = 1'b0;
        end else begin
            if (hs_edge && v_cnt != V_SAT) v_nxt = v_cnt + 1'b1;
            if (vs_edge) vs_pend_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        meas_bad_nxt = meas_bad;
        viol         = 1'b0;
        case (state)
            UNLOCKED: if (v_clr) begin
                state_nxt    = MEASURE;
                meas_bad_nxt = 1'b0;
            end
            MEASURE: begin
                if (hs_edge && !h_ok) meas_bad_nxt = 1'b1;
                if (v_clr) begin
                    // The closing edge's own period counts towards the frame.
                    if (!meas_bad && h_ok && v_ok) state_nxt = LOCKED;
                    meas_bad_nxt = 1'b0;
                end
            end
            LOCKED: if ((hs_edge && !h_ok) || (v_clr && !v_ok)) begin
                viol      = 1'b1;
                state_nxt = UNLOCKED;
            end
            default: state_nxt = UNLOCKED;
        endcase
        if (timeout) begin
            state_nxt = UNLOCKED;
            if (state == LOCKED) viol = 1'b1;
        end
    end

    // Positions use the next-state counters so the pixel lines up with rgb_r;
    // the output register then gives two clocks from pin to strobe.
    assign pix_hit = (state == LOCKED) && !viol && (ph_nxt == '0) &&
                     (px_nxt >= X_LO) && (px_nxt <= X_HI) &&
                     (v_nxt >= Y_LO) && (v_nxt <= Y_HI);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_r <= 1'b0; vs_r <= 1'b0; hs_q <= 1'b0; vs_q <= 1'b0;
            rgb_r <= '0;
            h_cnt <= '0; ph_cnt <= '0; px_cnt <= '0; v_cnt <= '0;
            vs_pend <= 1'b0; meas_bad <= 1'b0;
            state <= UNLOCKED;
            pix_valid_o <= 1'b0; sof_o <= 1'b0; err_o <= 1'b0; err_cnt_o <= '0;
            pix_x_o <= '0; pix_y_o <= '0; pix_rgb_o <= '0;
        end else begin
            hs_r <= vga_hs_i; vs_r <= vga_vs_i; hs_q <= hs_r; vs_q <= vs_r;
            rgb_r <= vga_rgb_i;
            h_cnt <= h_nxt; ph_cnt <= ph_nxt; px_cnt <= px_nxt; v_cnt <= v_nxt;
            vs_pend <= vs_pend_nxt; meas_bad <= meas_bad_nxt;
            state <= state_nxt;
            pix_valid_o <= pix_hit;
            sof_o <= pix_hit && (px_nxt == X_LO) && (v_nxt == Y_LO);
            err_o <= viol;
            if (viol && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 1'b1;
            if (pix_hit) begin
                pix_x_o   <= `X_POS_W'(px_nxt - X_LO);
                pix_y_o   <= `Y_POS_W'(v_nxt - Y_LO);
                pix_rgb_o <= rgb_r;
            end
        end
    end

`ifdef VGA_CAPTURE_CRC_EN
    localparam int CW = ((RGB_W + 7) / 8) * 8;
    logic [15:0] crc;
    logic        frame_full;   // current frame began while LOCKED, no violation since

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [CW-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = CW - 1; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ (((r[15] ^ d[i]) == 1'b1) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc <= 16'hFFFF; frame_full <= 1'b0;
            frame_crc_o <= '0; crc_valid_o <= 1'b0;
        end else begin
            crc_valid_o <= 1'b0;
            if (viol) begin
                crc <= 16'hFFFF;
                frame_full <= 1'b0;
            end else if (v_clr) begin
                if (state == LOCKED && frame_full) begin
                    crc_valid_o <= 1'b1;
                    frame_crc_o <= crc;
                end
                crc <= 16'hFFFF;
                frame_full <= (state_nxt == LOCKED);
            end else if (pix_hit) begin
                crc <= crc_upd(crc, CW'(rgb_r));
            end
        end
    end
`else
    assign frame_crc_o = '0;
    assign crc_valid_o = 1'b0;
`endif
endmodule
